scandoubler: RTL and testbench
==============================

SCANDOUBLER -- requirements
Module: scandoubler

Interface
REQ-001 SHALL have parameter HCNT_W, default 10, meaning input/output horizontal counter width (max 1024 pixels/line).
REQ-002 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports ce_x1  input  1  input pixel enable, and ce_x2  input  1  output pixel enable at exactly twice the ce_x1 rate.
REQ-005 SHALL have ports R_in, G_in, B_in  input  6 each  core pixel colour, sampled on ce_x1.
REQ-006 SHALL have ports HSync, VSync  input  1 each  core syncs, active-low, sampled on ce_x1.
REQ-007 SHALL have port scanlines  input  2  odd-line darkening: 0 none, 1 25%, 2 50%, 3 75%.
REQ-008 SHALL have ports R_out, G_out, B_out  output  6 each  doubled-rate pixel colour.
REQ-009 SHALL have ports HS_out, VS_out  output  1 each  doubled-rate syncs, active-low.

Function
REQ-010 Input side, on each ce_x1: write {R_in,G_in,B_in} to line buffer bank wr_bank at address hcnt_in; increment hcnt_in, saturating at 2^HCNT_W-1 with further writes suppressed.
REQ-011 Input HSync falling edge (registered prev value 1, current 0, at ce_x1): line_len <= hcnt_in, hcnt_in <= 0, wr_bank toggles, VS_out source vs_lat <= VSync.
REQ-012 Input HSync rising edge: hs_len <= number of ce_x1 cycles HSync was low (counter cleared at falling edge, saturating).
REQ-013 Output side, on each ce_x2: hcnt_out increments; when hcnt_out == line_len-1 it wraps to 0 and odd_line toggles.
REQ-014 An input HSync falling edge SHALL force hcnt_out <= 0 and odd_line <= 0 in that cycle, overriding REQ-013 (resync wins on simultaneous events).
REQ-015 While line_len == 0, hcnt_out SHALL wrap at 2^HCNT_W-1.
REQ-016 Output reads bank ~wr_bank at address hcnt_out; R/G/B_out registered on ce_x2, latency exactly one ce_x2 after address presentation.
REQ-017 HS_out SHALL be low while hcnt_out < hs_len, else high, registered with the same one-ce_x2 latency as pixels.
REQ-018 VS_out SHALL equal vs_lat, updated aligned to the output line start following each input HSync falling edge.
REQ-019 When odd_line=1: scanlines 1 -> c - (c>>2); 2 -> c>>1; 3 -> c>>2; per 6-bit channel, truncating, no overflow; odd_line=0 or scanlines=0 -> c unchanged.
REQ-020 Each input line SHALL therefore appear twice on output, second copy darkened per REQ-019, delayed one input line.
REQ-021 Output regs SHALL hold their values between ce_x2 pulses.

Reset
REQ-022 reset SHALL clear hcnt_in, hcnt_out, line_len, hs_len, wr_bank, odd_line; set vs_lat=1; R/G/B_out=0, HS_out=1, VS_out=1 on the next edge.
REQ-023 Reset asserted mid-line SHALL abort the line; buffer contents need not be cleared; first valid output follows the second input HSync falling edge after reset.

Structure
REQ-024 HCNT_W default, scanline level encodings and pixel width (18) SHALL live in shared package video_pkg, reused by the OSD stage.
REQ-025 The 2x2^HCNT_W x 18 dual-port storage SHALL be a sub-module line_buffer (one write port, one registered read port).

Verification
REQ-026 Lines of 400 ce_x1 pixels, HSync low 32 pixels, pixel value = column index -> each line output twice at ce_x2, 400 pixels each, HS_out low 32 ce_x2 per output line.
REQ-027 scanlines=2, input pixel R=G=B=40 -> even output line 40, odd output line 20; scanlines=1 -> 30; scanlines=3 -> 10.
REQ-028 Line length changes 400 -> 320 mid-frame -> next output lines wrap at 320, hcnt_out resynced to 0 at each input HSync fall, no glitch line longer than 400.
REQ-029 Line of 1100 ce_x1 with HCNT_W=10 -> hcnt_in saturates at 1023, no address wrap overwriting column 0.
REQ-030 VSync low for 3 input lines -> VS_out low for exactly 6 output lines, starting at an output line boundary.
REQ-031 reset pulsed at input pixel 200 -> outputs 0/1/1 next edge; correct doubled output after the second HSync fall.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video definitions: counter width default, pixel layout and scanline
// darkening levels used by the scandoubler and the OSD stage.
package video_pkg;

  localparam int HCNT_W_DEF = 10;
  localparam int CH_W       = 6;
  localparam int PIX_W      = 3 * CH_W;

  typedef enum logic [1:0] {
    SL_NONE = 2'd0,
    SL_25   = 2'd1,
    SL_50   = 2'd2,
    SL_75   = 2'd3
  } scanline_e;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } pixel_t;

endpackage

// File: rtl/line_buffer.sv
// Two-bank line store: one write port, one registered read port whose output
// register clears on reset and holds while rd_en is low.
module line_buffer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** (ADDR_W + 1);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  always_ff @(posedge clk_sys) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/scandoubler.sv
// Scandoubler: captures each input line at ce_x1 and replays it twice at ce_x2,
// the second copy darkened by the selected scanline level.
module scandoubler
  import video_pkg::*;
#(
  parameter int HCNT_W = HCNT_W_DEF
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce_x1,
  input  logic            ce_x2,
  input  logic [CH_W-1:0] R_in,
  input  logic [CH_W-1:0] G_in,
  input  logic [CH_W-1:0] B_in,
  input  logic            HSync,
  input  logic            VSync,
  input  logic [1:0]      scanlines,
  output logic [CH_W-1:0] R_out,
  output logic [CH_W-1:0] G_out,
  output logic [CH_W-1:0] B_out,
  output logic            HS_out,
  output logic            VS_out
);

  localparam logic [HCNT_W-1:0] HMAX = '1;

  logic              hs_prev, hs_fall, hs_rise;
  logic [HCNT_W-1:0] hcnt_in, line_len, hs_cnt, hs_len;
  logic              wr_bank, vs_lat;
  logic              wr_en, wr_sel;
  logic [HCNT_W-1:0] wr_addr;
  logic [HCNT_W-1:0] hcnt_out, wrap_at;
  logic              odd_line;
  logic [PIX_W-1:0]  rd_data_p1;
  pixel_t            pix_p1;
  logic              odd_p1, hs_p1, vs_p1;
  logic [1:0]        sl_p1;

  function automatic logic [HCNT_W-1:0] sat_inc(input logic [HCNT_W-1:0] v);
    return (v == HMAX) ? v : v + HCNT_W'(1);
  endfunction

  function automatic logic [CH_W-1:0] darken(input logic [CH_W-1:0] c,
                                             input logic odd, input logic [1:0] sl);
    logic [CH_W-1:0] res;
    res = c;
    if (odd) begin
      case (scanline_e'(sl))
        SL_25:   res = c - (c >> 2);
        SL_50:   res = c >> 1;
        SL_75:   res = c >> 2;
        default: res = c;
      endcase
    end
    return res;
  endfunction

  assign hs_fall = ce_x1 && hs_prev && !HSync;
  assign hs_rise = ce_x1 && !hs_prev && HSync;

  // Input stage: the pixel sampled on the HSync fall is column 0 of the new line
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_prev  <= 1'b1;
      hcnt_in  <= '0;
      line_len <= '0;
      hs_cnt   <= '0;
      hs_len   <= '0;
      wr_bank  <= 1'b0;
      vs_lat   <= 1'b1;
    end else if (ce_x1) begin
      hs_prev <= HSync;
      if (hs_fall) begin
        line_len <= hcnt_in;
        hcnt_in  <= HCNT_W'(1);
        wr_bank  <= ~wr_bank;
        vs_lat   <= VSync;
        hs_cnt   <= HCNT_W'(1);
      end else begin
        hcnt_in <= sat_inc(hcnt_in);
        if (!HSync) hs_cnt <= sat_inc(hs_cnt);
        if (hs_rise) hs_len <= hs_cnt;
      end
    end
  end

  assign wr_en   = ce_x1 && !reset && (hs_fall || (hcnt_in != HMAX));
  assign wr_sel  = hs_fall ? ~wr_bank : wr_bank;
  assign wr_addr = hs_fall ? '0 : hcnt_in;

  assign wrap_at = (line_len == '0) ? HMAX : line_len - HCNT_W'(1);

  // Output address stage (p0): input HSync fall resyncs the replay to column 0
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcnt_out <= '0;
      odd_line <= 1'b0;
    end else if (hs_fall) begin
      hcnt_out <= '0;
      odd_line <= 1'b0;
    end else if (ce_x2) begin
      if (hcnt_out == wrap_at) begin
        hcnt_out <= '0;
        odd_line <= ~odd_line;
      end else begin
        hcnt_out <= hcnt_out + HCNT_W'(1);
      end
    end
  end

  line_buffer #(.ADDR_W(HCNT_W), .DATA_W(PIX_W)) u_lbuf (
    .clk_sys (clk_sys),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_bank (wr_sel),
    .wr_addr (wr_addr),
    .wr_data ({R_in, G_in, B_in}),
    .rd_en   (ce_x2),
    .rd_bank (~wr_bank),
    .rd_addr (hcnt_out),
    .rd_data (rd_data_p1)
  );

  // Output register stage (p1): aligned with the registered buffer read
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      odd_p1 <= 1'b0;
      sl_p1  <= 2'd0;
    end else if (ce_x2) begin
      hs_p1  <= !(hcnt_out < hs_len);
      if (hcnt_out == '0) vs_p1 <= vs_lat;
      odd_p1 <= odd_line;
      sl_p1  <= scanlines;
    end
  end

  assign pix_p1 = rd_data_p1;
  assign R_out  = darken(pix_p1.r, odd_p1, sl_p1);
  assign G_out  = darken(pix_p1.g, odd_p1, sl_p1);
  assign B_out  = darken(pix_p1.b, odd_p1, sl_p1);
  assign HS_out = hs_p1;
  assign VS_out = vs_p1;

endmodule

// File: tb/tb_scandoubler.sv
// Scoreboard bench for scandoubler: line-level reference model predicts every
// ce_x2 output slot; a monitor compares DUT outputs against the queued values.
module tb_scandoubler;
  import video_pkg::*;

  localparam int HW    = 10;
  localparam int HMAXI = (1 << HW) - 1;

  logic       clk_sys = 1'b0;
  logic       reset, ce_x1, ce_x2, HSync, VSync;
  logic [5:0] R_in, G_in, B_in, R_out, G_out, B_out;
  logic [1:0] scanlines;
  logic       HS_out, VS_out;

  always #5 clk_sys = ~clk_sys;

  scandoubler #(.HCNT_W(HW)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ce_x1     (ce_x1),
    .ce_x2     (ce_x2),
    .R_in      (R_in),
    .G_in      (G_in),
    .B_in      (B_in),
    .HSync     (HSync),
    .VSync     (VSync),
    .scanlines (scanlines),
    .R_out     (R_out),
    .G_out     (G_out),
    .B_out     (B_out),
    .HS_out    (HS_out),
    .VS_out    (VS_out)
  );

  typedef struct packed {
    logic       chk;
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: the line currently being replayed and the line being captured
  logic [17:0] cur_line[$];
  logic [17:0] shown[$];
  logic        show_vs;
  bit          show_chk;
  int          pos, falls, m_hs_cnt, m_hs_len;
  logic        m_hs_prev;

  logic [1:0] sl_tab[4]  = '{2'd2, 2'd1, 2'd3, 2'd0};
  int         lens4[5]   = '{400, 400, 320, 320, 320};
  logic       vs4[5]     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  function automatic logic [5:0] dk(input logic [5:0] c, input bit odd, input logic [1:0] lvl);
    int v;
    v = int'(c);
    if (odd) begin
      case (lvl)
        2'd1:    v = v - v / 4;
        2'd2:    v = v / 2;
        2'd3:    v = v / 4;
        default: v = v;
      endcase
    end
    return 6'(v);
  endfunction

  // Expected output for the replay slot at position pos of the current line
  function automatic exp_t slot_exp();
    exp_t        e;
    int          len, col, copy;
    logic [17:0] px;
    bit          odd;
    len   = shown.size();
    col   = (len > 0) ? pos % len : 0;
    copy  = (len > 0) ? pos / len : 0;
    px    = (len > 0) ? shown[col] : 18'd0;
    odd   = (copy % 2) == 1;
    e.chk = show_chk && (len > 0);
    e.r   = dk(px[17:12], odd, scanlines);
    e.g   = dk(px[11:6], odd, scanlines);
    e.b   = dk(px[5:0], odd, scanlines);
    e.hs  = !(col < m_hs_len);
    e.vs  = show_vs;
    return e;
  endfunction

  task automatic model_reset();
    cur_line.delete();
    shown.delete();
    show_vs   = 1'b1;
    show_chk  = 1'b0;
    pos       = 0;
    falls     = 0;
    m_hs_cnt  = 0;
    m_hs_len  = 0;
    m_hs_prev = 1'b1;
  endtask

  task automatic model_pixel(input logic [17:0] px, input logic hs, input logic vs);
    if (m_hs_prev && !hs) begin
      shown    = cur_line;
      show_vs  = vs;
      falls++;
      show_chk = (falls >= 2);
      pos      = 0;
      cur_line.delete();
      cur_line.push_back(px);
      m_hs_cnt = 1;
    end else begin
      if (cur_line.size() < HMAXI) cur_line.push_back(px);
      if (!hs && m_hs_cnt < HMAXI) m_hs_cnt++;
      if (!m_hs_prev && hs) m_hs_len = m_hs_cnt;
    end
    m_hs_prev = hs;
  endtask

  task automatic drive_pixel(input logic [17:0] px, input logic hs, input logic vs);
    exp_t e;
    @(negedge clk_sys);
    {R_in, G_in, B_in} = px;
    HSync = hs;
    VSync = vs;
    ce_x1 = 1'b1;
    ce_x2 = 1'b1;
    e = slot_exp();
    sbq.push_back(e);
    pos++;
    model_pixel(px, hs, vs);
    @(negedge clk_sys);
    ce_x1 = 1'b0;
    ce_x2 = 1'b0;
    @(negedge clk_sys);
    ce_x2 = 1'b1;
    e = slot_exp();
    sbq.push_back(e);
    pos++;
    @(negedge clk_sys);
    ce_x2 = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_sys);
    reset = 1'b1;
    ce_x1 = 1'b0;
    ce_x2 = 1'b0;
    repeat (cycles) @(negedge clk_sys);
    checks++;
    if ({R_out, G_out, B_out, HS_out, VS_out} !== {18'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reset_state t=%0t got rgb=%0d/%0d/%0d hs=%0b vs=%0b want 0/0/0 hs=1 vs=1",
               $time, R_out, G_out, B_out, HS_out, VS_out);
    end
    reset = 1'b0;
    model_reset();
  endtask

  // mode 0: column index, 1: constant 40 grey, 2: random colour
  task automatic drive_line(input int len, input int mode, input logic vs, input int rst_at);
    logic [17:0] px;
    for (int c = 0; c < len; c++) begin
      if (c == rst_at) do_reset(1);
      case (mode)
        0:       px = 18'(c);
        1:       px = {6'd40, 6'd40, 6'd40};
        default: px = 18'($urandom);
      endcase
      drive_pixel(px, (c >= 32), vs);
    end
  endtask

  task automatic cmp(input exp_t e, input string nm);
    checks++;
    if ({R_out, G_out, B_out, HS_out, VS_out} !== {e.r, e.g, e.b, e.hs, e.vs}) begin
      failures++;
      $display("FAIL %s t=%0t got rgb=%0d/%0d/%0d hs=%0b vs=%0b want rgb=%0d/%0d/%0d hs=%0b vs=%0b",
               nm, $time, R_out, G_out, B_out, HS_out, VS_out, e.r, e.g, e.b, e.hs, e.vs);
    end
  endtask

  // Monitor: pops one expectation per ce_x2 edge, checks hold on idle edges
  bit   ce2_seen = 1'b0;
  bit   rst_seen = 1'b0;
  bit   hold_ok  = 1'b0;
  exp_t last;

  always @(posedge clk_sys) begin
    ce2_seen <= ce_x2;
    rst_seen <= reset;
  end

  always @(negedge clk_sys) begin
    if (rst_seen) begin
      hold_ok = 1'b0;
    end else if (ce2_seen) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow t=%0t got empty queue want an expected entry", $time);
      end else begin
        last    = sbq.pop_front();
        hold_ok = 1'b1;
        if (last.chk) cmp(last, "pixel");
      end
    end else if (hold_ok && last.chk) begin
      cmp(last, "hold");
    end
  end

  initial begin
    reset = 1'b1;
    ce_x1 = 1'b0;
    ce_x2 = 1'b0;
    {R_in, G_in, B_in} = 18'd0;
    HSync = 1'b1;
    VSync = 1'b1;
    scanlines = 2'd0;
    model_reset();
    do_reset(3);

    for (int i = 0; i < 4; i++) drive_line(400, 0, 1'b1, -1);

    for (int i = 0; i < 4; i++) begin
      scanlines = sl_tab[i];
      drive_line(400, 1, 1'b1, -1);
    end

    for (int i = 0; i < 5; i++) begin
      scanlines = 2'($urandom_range(0, 3));
      drive_line(lens4[i], 2, vs4[i], -1);
    end

    scanlines = 2'd2;
    drive_line(1100, 0, 1'b1, -1);
    drive_line(400, 0, 1'b1, -1);
    drive_line(400, 2, 1'b1, -1);

    drive_line(400, 2, 1'b1, 200);
    for (int i = 0; i < 3; i++) begin
      scanlines = 2'($urandom_range(0, 3));
      drive_line(400, 2, 1'b1, -1);
    end

    for (int i = 0; i < 4; i++) begin
      scanlines = 2'($urandom_range(0, 3));
      drive_line($urandom_range(40, 500), 2, 1'($urandom), -1);
    end
    drive_line(400, 0, 1'b1, -1);

    repeat (4) @(negedge clk_sys);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d entries left want 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
